// File: rtl/turn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : turn_scheduler
// Purpose  : Turn sequencer for Chicken Cha-Cha-Cha. Collects tile picks,
//            runs the compare handshake, advances positions, passes turns
//            and declares the winner. Optional pick timeout: TURN_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module turn_scheduler #(
  parameter int TRACK_LEN   = 24,
  parameter int POS_W       = 5,
  parameter int TIMEOUT_CYC = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         n_players,
  input  logic               pick_valid,
  input  logic [3:0]         pick_idx,
  output logic               cmp_req,
  output logic [3:0]         cmp_idx,
  input  logic               cmp_ack,
  input  logic               cmp_match,
  output logic [1:0]         cur_player,
  output logic [4*POS_W-1:0] pos_flat,
  output logic               wait_pick,
  output logic               turn_end,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_wait = 3'd1;
  localparam logic [2:0] c_st_req  = 3'd2;
  localparam logic [2:0] c_st_move = 3'd3;
  localparam logic [2:0] c_st_next = 3'd4;
  localparam logic [2:0] c_st_done = 3'd5;

  localparam logic [POS_W-1:0] c_finish = POS_W'(TRACK_LEN - 1);

  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic [1:0]             r_last;       // index of the last player in rotation
  logic [1:0]             w_last_nxt;
  logic [3:0][POS_W-1:0]  r_pos;
  logic [3:0][POS_W-1:0]  w_pos_nxt;
  logic [POS_W-1:0]       w_pos_inc;
  logic [3:0]             w_cmp_idx_nxt;
  logic [1:0]             w_cur_nxt;
  logic [1:0]             w_winner_nxt;
  logic                   w_start_ok;
  logic                   w_timeout;

  assign w_start_ok = start && ((r_state == c_st_idle) || (r_state == c_st_done));
  // Saturate at the finish square so the position can never wrap.
  assign w_pos_inc  = (r_pos[cur_player] == c_finish) ? c_finish
                                                      : r_pos[cur_player] + 1'b1;
  assign pos_flat   = r_pos;

`ifdef TURN_TIMEOUT_EN
  localparam int c_tmr_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYC - 1);

  logic [c_tmr_w-1:0] r_tmr;

  // Held at zero outside WAIT_PICK so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || (r_state != c_st_wait)) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  assign w_timeout = (r_state == c_st_wait) && (r_tmr == c_tmr_last);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC > 0);
  assign w_timeout    = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_last     <= 2'd1;
      r_pos      <= '0;
      cmp_req    <= 1'b0;
      cmp_idx    <= 4'd0;
      cur_player <= 2'd0;
      wait_pick  <= 1'b0;
      turn_end   <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_pos      <= w_pos_nxt;
      cmp_req    <= (w_state_nxt == c_st_req);
      cmp_idx    <= w_cmp_idx_nxt;
      cur_player <= w_cur_nxt;
      wait_pick  <= (w_state_nxt == c_st_wait);
      turn_end   <= (w_state_nxt == c_st_next);
      game_over  <= (w_state_nxt == c_st_done);
      winner     <= w_winner_nxt;
    end
  end

  // Next-state logic; a pick in the expiry cycle takes priority
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle, c_st_done: begin
        if (start) w_state_nxt = c_st_wait;
      end
      c_st_wait: begin
        if (pick_valid)     w_state_nxt = c_st_req;
        else if (w_timeout) w_state_nxt = c_st_next;
      end
      c_st_req: begin
        if (cmp_ack) w_state_nxt = cmp_match ? c_st_move : c_st_next;
      end
      c_st_move: begin
        w_state_nxt = (w_pos_inc == c_finish) ? c_st_done : c_st_wait;
      end
      c_st_next: begin
        w_state_nxt = c_st_wait;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Next values of the registered datapath outputs
  always_comb begin
    w_last_nxt    = r_last;
    w_pos_nxt     = r_pos;
    w_cmp_idx_nxt = cmp_idx;
    w_cur_nxt     = cur_player;
    w_winner_nxt  = winner;

    if (w_start_ok) begin
      case (n_players)
        2'd0:    w_last_nxt = 2'd3;
        2'd3:    w_last_nxt = 2'd2;
        default: w_last_nxt = 2'd1;
      endcase
      w_pos_nxt    = '0;
      w_cur_nxt    = 2'd0;
      w_winner_nxt = 2'd0;
    end

    if ((r_state == c_st_wait) && pick_valid) begin
      w_cmp_idx_nxt = pick_idx;
    end

    if (r_state == c_st_move) begin
      w_pos_nxt[cur_player] = w_pos_inc;
      if (w_pos_inc == c_finish) w_winner_nxt = cur_player;
    end

    if (r_state == c_st_next) begin
      w_cur_nxt = (cur_player == r_last) ? 2'd0 : cur_player + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_turn_scheduler.sv
`default_nettype none
// Scoreboard bench for turn_scheduler: a game-level model predicts each
// visible output event, and a monitor pops and compares as events appear.
module tb_turn_scheduler;

  localparam int TRACK_LEN = 24;
  localparam int POS_W     = 5;
`ifdef TURN_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 8;
`else
  localparam int TIMEOUT_CYC = 100;
`endif

  localparam int K_REQ    = 0;
  localparam int K_TURN   = 1;
  localparam int K_PLAYER = 2;
  localparam int K_POS    = 3;
  localparam int K_WIN    = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [1:0]         n_players = 2'd0;
  logic               pick_valid = 1'b0;
  logic [3:0]         pick_idx = 4'd0;
  logic               cmp_req;
  logic [3:0]         cmp_idx;
  logic               cmp_ack = 1'b0;
  logic               cmp_match = 1'b0;
  logic [1:0]         cur_player;
  logic [4*POS_W-1:0] pos_flat;
  logic               wait_pick;
  logic               turn_end;
  logic               game_over;
  logic [1:0]         winner;

  always #5 clk = ~clk;

  turn_scheduler #(
    .TRACK_LEN  (TRACK_LEN),
    .POS_W      (POS_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_players  (n_players),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx),
    .cmp_req    (cmp_req),
    .cmp_idx    (cmp_idx),
    .cmp_ack    (cmp_ack),
    .cmp_match  (cmp_match),
    .cur_player (cur_player),
    .pos_flat   (pos_flat),
    .wait_pick  (wait_pick),
    .turn_end   (turn_end),
    .game_over  (game_over),
    .winner     (winner)
  );

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Game-level reference model
  int m_pos[4];
  int m_cur     = 0;
  int m_cnt     = 2;
  bit m_in_game = 1'b0;
  bit m_over    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] m_flat();
    logic [31:0] r;
    r = '0;
    for (int p = 0; p < 4; p++) r[p*POS_W +: POS_W] = POS_W'(m_pos[p]);
    return r;
  endfunction

  function automatic int map_cnt(input logic [1:0] n);
    case (n)
      2'd0:    return 4;
      2'd3:    return 3;
      default: return 2;
    endcase
  endfunction

  // Monitor
  logic [3:0]         exp_idx  = 4'd0;
  logic               prev_req = 1'b0;
  logic               prev_go  = 1'b0;
  logic [1:0]         prev_cp  = 2'd0;
  logic [4*POS_W-1:0] prev_pos = '0;

  task automatic expect_ev(input int k, input logic [31:0] act, input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected output event, got %0d expected none", name, act);
      return;
    end
    e = sb_q.pop_front();
    check({name, "_kind"}, k, e.kind);
    check(name, act, e.data);
    if (k == K_REQ) exp_idx = e.data[3:0];
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (cmp_req && !prev_req)     expect_ev(K_REQ, 32'(cmp_idx), "cmp_idx");
      if (cmp_req)                  check("cmp_idx_hold", 32'(cmp_idx), 32'(exp_idx));
      if (turn_end)                 expect_ev(K_TURN, 32'(cur_player), "turn_end_player");
      if (cur_player !== prev_cp)   expect_ev(K_PLAYER, 32'(cur_player), "cur_player");
      if (pos_flat !== prev_pos)    expect_ev(K_POS, 32'(pos_flat), "pos_flat");
      if (game_over && !prev_go)    expect_ev(K_WIN, 32'(winner), "winner");
    end
    prev_req = cmp_req;
    prev_go  = game_over;
    prev_cp  = cur_player;
    prev_pos = pos_flat;
  end

  task automatic check_zero(input string tag);
    check({tag, "_cmp_req"},    32'(cmp_req), 0);
    check({tag, "_cmp_idx"},    32'(cmp_idx), 0);
    check({tag, "_cur_player"}, 32'(cur_player), 0);
    check({tag, "_pos_flat"},   32'(pos_flat), 0);
    check({tag, "_wait_pick"},  32'(wait_pick), 0);
    check({tag, "_turn_end"},   32'(turn_end), 0);
    check({tag, "_game_over"},  32'(game_over), 0);
    check({tag, "_winner"},     32'(winner), 0);
  endtask

  task automatic do_start(input logic [1:0] n, input bit with_pick);
    bit accepted;
    @(negedge clk);
    start      = 1'b1;
    n_players  = n;
    pick_valid = with_pick;
    pick_idx   = 4'hA;
    accepted   = !m_in_game;
    if (accepted) begin
      if (m_cur != 0) push(K_PLAYER, 0);
      if (m_flat() != 0) push(K_POS, 0);
      for (int p = 0; p < 4; p++) m_pos[p] = 0;
      m_cur     = 0;
      m_cnt     = map_cnt(n);
      m_in_game = 1'b1;
      m_over    = 1'b0;
    end
    @(negedge clk);
    start      = 1'b0;
    pick_valid = 1'b0;
    if (accepted) begin
      check("start_wait_pick", 32'(wait_pick), 1);
      check("start_cmp_req",   32'(cmp_req), 0);
      check("start_game_over", 32'(game_over), 0);
    end
  endtask

  task automatic do_turn(input bit match, input int ack_dly, input int pick_dly,
                         input logic [3:0] idx, input bit noise);
    int n;
    n = 0;
    while (wait_pick !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (wait_pick !== 1'b1) begin
      check("wait_pick_bound", 32'(wait_pick), 1);
      return;
    end
    for (int i = 0; i < pick_dly; i++) begin
      if (noise) cmp_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    pick_valid = 1'b1;
    pick_idx   = idx;
    cmp_ack    = 1'b0;
    push(K_REQ, 32'(idx));
    @(negedge clk);
    pick_valid = 1'b0;
    check("req_latency", 32'(cmp_req), 1);
    for (int i = 0; i < ack_dly; i++) begin
      if (noise) begin
        pick_valid = 1'($urandom_range(0, 1));
        pick_idx   = 4'($urandom);
        start      = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
    end
    pick_valid = 1'b0;
    start      = 1'b0;
    cmp_ack    = 1'b1;
    cmp_match  = match;
    if (match) begin
      m_pos[m_cur]++;
      push(K_POS, m_flat());
      if (m_pos[m_cur] == TRACK_LEN - 1) begin
        push(K_WIN, 32'(m_cur));
        m_over    = 1'b1;
        m_in_game = 1'b0;
      end
    end else begin
      push(K_TURN, 32'(m_cur));
      m_cur = (m_cur + 1) % m_cnt;
      push(K_PLAYER, 32'(m_cur));
    end
    @(negedge clk);
    cmp_ack   = 1'b0;
    cmp_match = 1'b0;
    check("ack_drops_req", 32'(cmp_req), 0);
    check("turn_end_timing", 32'(turn_end), 32'(!match));
    @(negedge clk);
    check("post_turn_wait_pick", 32'(wait_pick), 32'(!m_over));
    check("post_turn_game_over", 32'(game_over), 32'(m_over));
  endtask

  initial begin
    for (int p = 0; p < 4; p++) m_pos[p] = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Start with a simultaneous pick: only start acts; 3 players
    do_start(2'd3, 1'b1);
    check("start_pick_ignored", 32'(cmp_req), 0);

    do_turn(1'b1, 2, 0, 4'h5, 1'b0);
    check("first_match_player", 32'(cur_player), 0);

    repeat (3) do_turn(1'b0, 0, 0, 4'($urandom), 1'b0);

    repeat (22) do_turn(1'b1, 0, 1, 4'($urandom), 1'b1);
    check("win_game_over", 32'(game_over), 1);
    check("win_winner", 32'(winner), 0);

    // Picks in DONE are ignored
    @(negedge clk);
    pick_valid = 1'b1;
    @(negedge clk);
    pick_valid = 1'b0;
    @(negedge clk);
    check("done_pick_ignored", 32'(cmp_req), 0);
    check("done_held", 32'(game_over), 1);

    // Restart with 4 players clears positions, then reset mid-handshake
    do_start(2'd0, 1'b0);
    pick_valid = 1'b1;
    pick_idx   = 4'h9;
    push(K_REQ, 32'h9);
    @(negedge clk);
    pick_valid = 1'b0;
    check("rst_test_req", 32'(cmp_req), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    check("sb_empty_after_rst", 32'(sb_q.size()), 0);
    for (int p = 0; p < 4; p++) m_pos[p] = 0;
    m_cur     = 0;
    m_in_game = 1'b0;
    m_over    = 1'b0;

`ifdef TURN_TIMEOUT_EN
    begin
      int n;
      do_start(2'd2, 1'b0);
      push(K_TURN, 0);
      m_cur = 1;
      push(K_PLAYER, 1);
      n = 0;
      while (turn_end !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycles", 32'(n), 8);
      @(negedge clk);
      check("timeout_player", 32'(cur_player), 1);
    end
`endif

    // Randomized games
    for (int g = 0; g < 5; g++) begin
      int turns;
      if (!m_in_game) do_start(2'($urandom), 1'b0);
      turns = 0;
      while (m_in_game && turns < 400) begin
        do_turn($urandom_range(0, 99) < 70, $urandom_range(0, 2),
                $urandom_range(0, 2), 4'($urandom), 1'b1);
        turns++;
      end
      check("game_finished", 32'(m_over), 1);
      repeat (3) @(negedge clk);
      check("game_winner", 32'(winner), 32'(m_cur));
      check("sb_drained", 32'(sb_q.size()), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
